// File: rtl/step_pulse_gen.sv
// Hand-clock step pulse generator.
// Synchronizes and debounces a raw push-button. It emits a single-cycle step
// strobe on each press, with an optional hold-to-auto-repeat mode. It also
// keeps a 16-bit wrap-around count of the steps it has issued.
module step_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        button_in,
  input  logic        auto_repeat_en,
  output logic        step_pulse,
  output logic        button_level,
  output logic [15:0] step_count,
  output logic        repeating
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1. The repeat
  // timer is shared by both repeat intervals, so it is sized for the longer one.
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic                   pulse_q, pulse_d;
  logic [15:0]            count_q, count_d;
  logic                   sync_level;

  assign sync_level = sync_q[SYNC_STAGES-1];

  // Shift the raw button level one stage down the synchronizer chain each cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], button_in};
  end

  // Debounce: the level flips only after the synchronized input has disagreed
  // with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    // NOTE: every output of an always_comb gets a default on entry, so no path
    // through the block can leave a value unassigned and infer a latch.
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_level != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sync_level;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Press/repeat FSM. It acts on the new debounced level, so the first
  // pulse lands in the same cycle that button_level rises. A release always
  // wins over a same-cycle repeat expiry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (level_d) begin
          state_d = ST_HOLD;
          timer_d = '0;
          pulse_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!level_d) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (!auto_repeat_en) begin
          timer_d = '0;
        end else if (timer_q == DELAY_LAST) begin
          state_d = ST_REPEAT;
          timer_d = '0;
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!level_d) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (!auto_repeat_en) begin
          state_d = ST_HOLD;
          timer_d = '0;
        end else if (timer_q == PERIOD_LAST) begin
          timer_d = '0;
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Step counter: it advances together with the registered pulse, so the new
  // count is visible in the same cycle as step_pulse.
  always_comb begin
    count_d = pulse_d ? count_q + 16'd1 : count_q;
  end

  // All state registers. Reset clears everything, which cuts off any pulse
  // that is in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      pulse_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every flop samples the
      // pre-edge value of the others regardless of statement order.
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      pulse_q  <= pulse_d;
      count_q  <= count_d;
    end
  end

  assign step_pulse   = pulse_q;
  assign button_level = level_q;
  assign step_count   = count_q;
  assign repeating    = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Testbench for step_pulse_gen.
// It compares the main instance cycle by cycle against a reference model that
// is written from the press/hold/repeat rules. A vector table and hand-written
// sequences cover latency, bounce, repeat timing and reset. A second instance,
// configured for a pulse every cycle, covers the 16-bit count wrap.
module tb_step_pulse_gen;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        button_in;
  logic        auto_repeat_en;
  logic        step_pulse;
  logic        button_level;
  logic [15:0] step_count;
  logic        repeating;

  logic        w_reset;
  logic        w_btn;
  logic        w_en;
  logic        w_pulse;
  logic        w_level;
  logic [15:0] w_count;
  logic        w_rep;

  always #5 clock = ~clock;

  step_pulse_gen #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .button_in(button_in), .auto_repeat_en(auto_repeat_en),
    .step_pulse(step_pulse), .button_level(button_level), .step_count(step_count),
    .repeating(repeating)
  );

  step_pulse_gen #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .REPEAT_DELAY(1), .REPEAT_PERIOD(1)
  ) dut_wrap (
    .clock(clock), .reset(w_reset), .button_in(w_btn), .auto_repeat_en(w_en),
    .step_pulse(w_pulse), .button_level(w_level), .step_count(w_count),
    .repeating(w_rep)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ph_pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  bit m_q[$];     // last SYNC button samples, oldest first
  int m_run;      // consecutive cycles the synchronized input disagreed
  bit m_level;
  bit m_pressed;  // a press has been accepted and not yet released
  bit m_rep;      // auto-repeat cadence is active
  int m_wait;     // enabled hold cycles since the last pulse
  bit m_pulse;
  int m_count;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    m_run = 0; m_level = 0; m_pressed = 0; m_rep = 0;
    m_wait = 0; m_pulse = 0; m_count = 0;
  endtask

  task automatic model_step(input bit btn, input bit en);
    bit sl;
    sl = m_q.pop_front();
    m_q.push_back(btn);
    if (sl != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = sl;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_pulse = 0;
    if (!m_pressed) begin
      if (m_level) begin
        m_pressed = 1; m_pulse = 1; m_wait = 0; m_rep = 0;
      end
    end else if (!m_level) begin
      m_pressed = 0; m_rep = 0;
    end else if (!en) begin
      m_wait = 0; m_rep = 0;
    end else begin
      m_wait++;
      if (m_wait == (m_rep ? RP : RD)) begin
        m_pulse = 1; m_wait = 0; m_rep = 1;
      end
    end
    if (m_pulse) m_count = (m_count + 1) % 65536;
  endtask

  // Apply one cycle of inputs, then compare all outputs to the model at the
  // falling edge.
  task automatic tick(input bit btn, input bit en);
    button_in = btn;
    auto_repeat_en = en;
    @(posedge clock);
    model_step(btn, en);
    @(negedge clock);
    cyc++;
    check($sformatf("cycle%0d_outputs", cyc),
          {13'd0, step_pulse, button_level, repeating, step_count},
          {13'd0, m_pulse, m_level, m_rep, m_count[15:0]});
    ph_pulses += int'(step_pulse);
  endtask

  typedef struct {
    bit btn;
    bit en;
    int cycles;
    int pulses;
    bit level;
    bit rep;
  } vec_t;

  task automatic main_seq();
    vec_t vecs[$];
    int rise_at;
    int offs[$];
    int exp_offs[$];
    int pulse_tick;
    bit en_r;

    vecs.push_back('{1'b0, 1'b0, 10, 0, 1'b0, 1'b0});  // release of the clean press
    for (int i = 0; i < 3; i++) begin                   // bounce: 1,1,0,0 x3
      vecs.push_back('{1'b1, 1'b0, 2, 0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 2, 0, 1'b0, 1'b0});
    end
    vecs.push_back('{1'b1, 1'b0, 12, 1, 1'b1, 1'b0});  // stable after bounce
    vecs.push_back('{1'b0, 1'b0, 10, 0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 6, 1, 1'b1, 1'b0});   // press with repeat
    vecs.push_back('{1'b1, 1'b1, 12, 1, 1'b1, 1'b1});  // first repeat at +10
    vecs.push_back('{1'b1, 1'b0, 8, 0, 1'b1, 1'b0});   // repeat disabled: HOLD
    vecs.push_back('{1'b1, 1'b1, 10, 1, 1'b1, 1'b1});  // pulse 10 after re-enable
    vecs.push_back('{1'b1, 1'b1, 4, 0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 10, 0, 1'b0, 1'b0});

    // Clean press: button_level and the single pulse arrive on tick 6.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    rise_at = 0;
    ph_pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b1, 1'b0);
      if (button_level && rise_at == 0) rise_at = i;
      if (i == 6) check("t1_pulse_at_rise", {31'd0, step_pulse}, 32'd1);
    end
    check("t1_rise_latency", rise_at, 6);
    check("t1_pulse_count", ph_pulses, 1);
    check("t1_step_count", {16'd0, step_count}, 32'd1);

    foreach (vecs[i]) begin
      ph_pulses = 0;
      for (int c = 0; c < vecs[i].cycles; c++) tick(vecs[i].btn, vecs[i].en);
      check($sformatf("vec%0d_pulses", i), ph_pulses, vecs[i].pulses);
      check($sformatf("vec%0d_level", i), {31'd0, button_level}, {31'd0, vecs[i].level});
      check($sformatf("vec%0d_repeating", i), {31'd0, repeating}, {31'd0, vecs[i].rep});
    end

    // Auto-repeat: record pulse offsets relative to the rising edge. The
    // release reaches button_level at offset 40, which is also a repeat
    // expiry, so that pulse must be suppressed.
    for (int i = 0; i < 20 && !button_level; i++) tick(1'b1, 1'b1);
    check("t3_rise", {31'd0, button_level}, 32'd1);
    if (step_pulse) offs.push_back(0);
    for (int off = 1; off <= 44; off++) begin
      tick(off <= 34, 1'b1);
      if (step_pulse) offs.push_back(off);
      if (off == 9)  check("t3_rep_off9", {31'd0, repeating}, 32'd0);
      if (off == 10) check("t3_rep_off10", {31'd0, repeating}, 32'd1);
    end
    exp_offs = '{0, 10, 15, 20, 25, 30, 35};
    check("t3_pulse_total", offs.size(), exp_offs.size());
    foreach (exp_offs[i])
      check($sformatf("t3_pulse%0d_offset", i), (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
    check("t3_idle_after_release", {30'd0, button_level, repeating}, 32'd0);

    // Reset while in REPEAT with the button held.
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1);
    check("t6_in_repeat", {31'd0, repeating}, 32'd1);
    #2 reset = 1'b0;
    #1 check("t6_reset_outputs", {13'd0, step_pulse, button_level, repeating, step_count}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    ph_pulses = 0;
    pulse_tick = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, 1'b0);
      if (step_pulse && pulse_tick == 0) pulse_tick = i;
    end
    check("t6_pulse_tick", pulse_tick, 6);
    check("t6_pulse_count", ph_pulses, 1);
    check("t6_step_count", {16'd0, step_count}, 32'd1);

    // Randomized runs of button level, with occasional toggles of the enable.
    en_r = 1'b0;
    for (int b = 0; b < 150; b++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) == 0) en_r = ~en_r;
        tick(lvl, en_r);
      end
    end
  endtask

  // Wrap test on the every-cycle instance: pulse 65535 leaves 0xFFFF and the
  // next pulse wraps the count to zero.
  task automatic wrap_seq();
    int n;
    bit done;
    n = 0;
    done = 0;
    w_btn = 1'b1;
    w_en = 1'b1;
    for (int c = 0; c < 70000 && !done; c++) begin
      @(negedge clock);
      if (w_pulse) begin
        n++;
        if (n == 65535) check("wrap_at_ffff", {16'd0, w_count}, 32'h0000_ffff);
        if (n == 65536) begin
          check("wrap_to_zero", {16'd0, w_count}, 32'd0);
          done = 1;
        end
      end
    end
    if (!done) check("wrap_timeout_pulses", n, 65536);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    w_reset = 1'b0;
    button_in = 1'b0;
    auto_repeat_en = 1'b0;
    w_btn = 1'b0;
    w_en = 1'b0;
    model_reset();
    @(negedge clock);
    check("reset_outputs", {13'd0, step_pulse, button_level, repeating, step_count}, 32'd0);
    check("reset_wrap_outputs", {13'd0, w_pulse, w_level, w_rep, w_count}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    w_reset = 1'b1;
    fork
      main_seq();
      wrap_seq();
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
